surf_cout_dout_tx: RTL and testbench

//  SURF-side transmit framer for the COUT/DOUT links: the far end of the TURFIO COUT/DOUT receive path.

---
 rtl/surf_cout_dout_tx_if.sv | 33 +++
 rtl/surf_cout_dout_tx.sv | 182 ++++++++++++++++++
 tb/tb_surf_cout_dout_tx.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/surf_cout_dout_tx_if.sv
// surf_cout_dout_tx_if
//   Handshake bundle between the SURF response/event sources and the
//   COUT/DOUT transmit framer.
//   Signals:
//     cout_word_i    32  response word offered for transmission on COUT
//     cout_valid_i    1  response word valid; held by the source until ack
//     cout_ack_o      1  one-cycle pulse: response word taken by the framer
//     s_dout_tdata    8  event data byte (AXI4-Stream)
//     s_dout_tvalid   1  AXI4-Stream valid
//     s_dout_tready   1  AXI4-Stream ready
//     s_dout_tlast    1  last byte of the event frame
//   Modports:
//     master  the source side (drives words and stream beats)
//     slave   the framer side (drives ack and ready)
interface surf_cout_dout_tx_if;
  logic [31:0] cout_word_i;
  logic        cout_valid_i;
  logic        cout_ack_o;
  logic [7:0]  s_dout_tdata;
  logic        s_dout_tvalid;
  logic        s_dout_tready;
  logic        s_dout_tlast;

  modport master (
    output cout_word_i, cout_valid_i, s_dout_tdata, s_dout_tvalid, s_dout_tlast,
    input  cout_ack_o, s_dout_tready
  );

  modport slave (
    input  cout_word_i, cout_valid_i, s_dout_tdata, s_dout_tvalid, s_dout_tlast,
    output cout_ack_o, s_dout_tready
  );
endinterface

// File: rtl/surf_cout_dout_tx.sv
// surf_cout_dout_tx
//   SURF-side transmit framer for the COUT/DOUT links. COUT carries 32-bit
//   response words as eight nibbles per word, aligned to an 8-cycle phase
//   that sync_i can force back to zero. DOUT carries event bytes, one per
//   cycle, with idle filler and a repeating training pattern on request.
//   The parallel outputs feed external OSERDES primitives.
//   Ports:
//     sysclk_i         system clock
//     sysclk_rst_i     synchronous active-high reset
//     sync_i           word-alignment pulse; phase is 0 on the following cycle
//     cout_train_i     level: send TRAIN_SEQUENCE on COUT
//     dout_train_i     level: send TRAIN_SEQUENCE on DOUT
//     bus              response word / event stream handshakes (slave side)
//     cout_o           COUT nibble, bit 3 sent first
//     dout_o           DOUT byte, bit 7 sent first
//     dout_underrun_o  one-cycle pulse: filler byte inserted inside a frame
//     dout_training_o  DOUT is sending the training pattern
module surf_cout_dout_tx #(
  parameter logic [31:0] TRAIN_SEQUENCE = 32'hA55A6996,
  parameter logic [7:0]  IDLE_BYTE      = 8'h00
) (
  input  logic                      sysclk_i,
  input  logic                      sysclk_rst_i,
  input  logic                      sync_i,
  input  logic                      cout_train_i,
  input  logic                      dout_train_i,
  surf_cout_dout_tx_if.slave        bus,
  output logic [3:0]                cout_o,
  output logic [7:0]                dout_o,
  output logic                      dout_underrun_o,
  output logic                      dout_training_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA  = 2'd1,
    TRAIN = 2'd2
  } dout_state_t;

  logic [2:0]  phase;
  logic [2:0]  phase_next;
  logic        load;
  logic [31:0] load_word;
  logic [31:0] shift_reg;

  dout_state_t state;
  dout_state_t state_next;
  logic        tready;
  logic        beat;
  logic        underrun_next;
  logic [7:0]  dout_next;

  // Training byte shown while phase[1:0] equals sel; MSB byte at sel 0.
  function automatic logic [7:0] train_byte(input logic [1:0] sel);
    logic [7:0] b;
    case (sel)
      2'd0:    b = TRAIN_SEQUENCE[31:24];
      2'd1:    b = TRAIN_SEQUENCE[23:16];
      2'd2:    b = TRAIN_SEQUENCE[15:8];
      default: b = TRAIN_SEQUENCE[7:0];
    endcase
    return b;
  endfunction

  // sync_i overrides the free-running increment so the next cycle is phase 0.
  always_comb begin
    phase_next = sync_i ? 3'd0 : phase + 3'd1;
  end

  always_ff @(posedge sysclk_i) begin
    if (sysclk_rst_i) begin
      phase <= 3'd0;
    end else begin
      phase <= phase_next;
    end
  end

  // A new COUT word is chosen at the end of every 8-cycle word, or early on
  // sync_i, which truncates whatever word was in flight.
  assign load = (phase == 3'd7) || sync_i;

  always_comb begin
    load_word = 32'h0;
    if (cout_train_i) begin
      load_word = TRAIN_SEQUENCE;
    end else if (bus.cout_valid_i) begin
      load_word = bus.cout_word_i;
    end
  end

  // Training words are not responses, so they never acknowledge the source.
  assign bus.cout_ack_o = load && !cout_train_i && bus.cout_valid_i && !sysclk_rst_i;

  // The first nibble goes straight to cout_o at load so that cout_o shows
  // nibble k of the word while phase equals k; shift_reg holds the rest.
  always_ff @(posedge sysclk_i) begin
    if (sysclk_rst_i) begin
      cout_o    <= 4'h0;
      shift_reg <= 32'h0;
    end else if (load) begin
      cout_o    <= load_word[31:28];
      shift_reg <= {load_word[27:0], 4'h0};
    end else begin
      cout_o    <= shift_reg[31:28];
      shift_reg <= {shift_reg[27:0], 4'h0};
    end
  end

  // DOUT state register.
  always_ff @(posedge sysclk_i) begin
    if (sysclk_rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Training is only entered or left at phase[1:0]==3 so the pattern always
  // starts at its MSB byte and leaves on a complete 4-byte boundary. A frame
  // in progress holds off training until tlast.
  always_comb begin
    state_next    = state;
    tready        = 1'b0;
    beat          = 1'b0;
    underrun_next = 1'b0;
    case (state)
      IDLE: begin
        if (dout_train_i && (phase[1:0] == 2'd3)) begin
          state_next = TRAIN;
        end else begin
          tready = 1'b1;
          beat   = bus.s_dout_tvalid;
          if (beat && !bus.s_dout_tlast) begin
            state_next = DATA;
          end
        end
      end
      DATA: begin
        tready        = 1'b1;
        beat          = bus.s_dout_tvalid;
        underrun_next = !bus.s_dout_tvalid;
        if (beat && bus.s_dout_tlast) begin
          state_next = IDLE;
        end
      end
      TRAIN: begin
        if (!dout_train_i && (phase[1:0] == 2'd3)) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // The training byte is picked from the phase of the cycle it will appear
  // in, which keeps it aligned even when sync_i moves the phase.
  always_comb begin
    dout_next = IDLE_BYTE;
    if (state_next == TRAIN) begin
      dout_next = train_byte(phase_next[1:0]);
    end else if (beat) begin
      dout_next = bus.s_dout_tdata;
    end
  end

  assign bus.s_dout_tready = tready && !sysclk_rst_i;

  always_ff @(posedge sysclk_i) begin
    if (sysclk_rst_i) begin
      dout_o          <= 8'h00;
      dout_underrun_o <= 1'b0;
    end else begin
      dout_o          <= dout_next;
      dout_underrun_o <= underrun_next;
    end
  end

  assign dout_training_o = (state == TRAIN);

endmodule

// File: tb/tb_surf_cout_dout_tx.sv
// tb_surf_cout_dout_tx
//   Randomized bench for surf_cout_dout_tx. Random response words, event
//   stream beats, training requests and sync pulses are driven into the
//   framer and every output is compared each cycle with a reference model
//   that tracks the word phase, the word being sent and the frame/training
//   status as plain variables.
module tb_surf_cout_dout_tx;

  localparam logic [31:0] TRAIN_SEQ = 32'hA55A6996;
  localparam logic [7:0]  IDLE_B    = 8'h00;

  logic       sysclk;
  logic       rst;
  logic       sync;
  logic       cout_train;
  logic       dout_train;
  logic [3:0] cout;
  logic [7:0] dout;
  logic       underrun;
  logic       training;

  surf_cout_dout_tx_if bus_if ();

  surf_cout_dout_tx #(
    .TRAIN_SEQUENCE (TRAIN_SEQ),
    .IDLE_BYTE      (IDLE_B)
  ) dut (
    .sysclk_i        (sysclk),
    .sysclk_rst_i    (rst),
    .sync_i          (sync),
    .cout_train_i    (cout_train),
    .dout_train_i    (dout_train),
    .bus             (bus_if.slave),
    .cout_o          (cout),
    .dout_o          (dout),
    .dout_underrun_o (underrun),
    .dout_training_o (training)
  );

  // 100 MHz system clock.
  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  int n_checks = 0;
  int n_fails  = 0;

  // Reference model state: values expected on the registered outputs in the
  // current cycle, plus the phase and the word being sent.
  int          m_phase;
  logic [31:0] m_word;
  logic [3:0]  m_cout;
  logic [7:0]  m_dout;
  logic        m_under;
  logic        m_frame;
  logic        m_train;
  logic        last_ack;
  logic        last_beat;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("[TB] FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    m_phase   = 0;
    m_word    = 32'h0;
    m_cout    = 4'h0;
    m_dout    = 8'h00;
    m_under   = 1'b0;
    m_frame   = 1'b0;
    m_train   = 1'b0;
    last_ack  = 1'b0;
    last_beat = 1'b0;
  endtask

  // Random input drive; the sources keep an offer stable until the model
  // says it was taken.
  task automatic drive_inputs();
    sync = ($urandom_range(0, 39) == 0);
    if ($urandom_range(0, 49) == 0) cout_train = ~cout_train;
    if ($urandom_range(0, 49) == 0) dout_train = ~dout_train;
    if (!bus_if.cout_valid_i || last_ack) begin
      bus_if.cout_valid_i = ($urandom_range(0, 2) != 0);
      bus_if.cout_word_i  = $urandom;
    end
    if (!bus_if.s_dout_tvalid || last_beat) begin
      bus_if.s_dout_tvalid = ($urandom_range(0, 3) != 0);
      bus_if.s_dout_tdata  = 8'($urandom);
      bus_if.s_dout_tlast  = ($urandom_range(0, 4) == 0);
    end
  endtask

  // Compare this cycle's outputs with the model, then advance the model by
  // one clock using the inputs present now.
  task automatic step_model();
    logic load;
    logic exp_ack;
    logic exp_tready;
    logic beat;
    logic was_frame;
    int   n_phase;

    checkOutput("cout_o", 32'(cout), 32'(m_cout));
    checkOutput("dout_o", 32'(dout), 32'(m_dout));
    checkOutput("underrun", 32'(underrun), 32'(m_under));
    checkOutput("training", 32'(training), 32'(m_train));

    load    = (m_phase == 7) || sync;
    exp_ack = load && !cout_train && bus_if.cout_valid_i;
    if (m_train)      exp_tready = 1'b0;
    else if (m_frame) exp_tready = 1'b1;
    else              exp_tready = !(dout_train && (m_phase % 4 == 3));
    checkOutput("cout_ack", 32'(bus_if.cout_ack_o), 32'(exp_ack));
    checkOutput("tready", 32'(bus_if.s_dout_tready), 32'(exp_tready));

    n_phase = sync ? 0 : (m_phase + 1) % 8;

    // COUT: the chosen word is shown nibble k at phase k.
    if (load) begin
      if (cout_train)               m_word = TRAIN_SEQ;
      else if (bus_if.cout_valid_i) m_word = bus_if.cout_word_i;
      else                          m_word = 32'h0;
    end
    m_cout = 4'((m_word >> (28 - 4 * n_phase)) & 32'hF);

    // DOUT: frame and training bookkeeping.
    beat      = bus_if.s_dout_tvalid && exp_tready;
    was_frame = m_frame;
    if (m_train) begin
      if (!dout_train && (m_phase % 4 == 3)) m_train = 1'b0;
    end else if (m_frame) begin
      if (beat && bus_if.s_dout_tlast) m_frame = 1'b0;
    end else begin
      if (dout_train && (m_phase % 4 == 3)) m_train = 1'b1;
      else if (beat && !bus_if.s_dout_tlast) m_frame = 1'b1;
    end
    m_under = was_frame && !beat;
    if (m_train)   m_dout = 8'((TRAIN_SEQ >> (24 - 8 * (n_phase % 4))) & 32'hFF);
    else if (beat) m_dout = bus_if.s_dout_tdata;
    else           m_dout = IDLE_B;

    m_phase   = n_phase;
    last_ack  = exp_ack;
    last_beat = beat;
  endtask

  task automatic applyStimulus(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      drive_inputs();
      @(negedge sysclk);
      step_model();
      @(posedge sysclk);
      #1;
    end
  endtask

  // Reset is held two cycles; handshakes must be quiet as soon as it is
  // asserted and every registered output cleared after the first edge.
  task automatic do_reset();
    rst = 1'b1;
    @(negedge sysclk);
    checkOutput("rst_ack", 32'(bus_if.cout_ack_o), 32'h0);
    checkOutput("rst_tready", 32'(bus_if.s_dout_tready), 32'h0);
    @(posedge sysclk);
    #1;
    @(negedge sysclk);
    checkOutput("rst_cout", 32'(cout), 32'h0);
    checkOutput("rst_dout", 32'(dout), 32'h0);
    checkOutput("rst_underrun", 32'(underrun), 32'h0);
    checkOutput("rst_training", 32'(training), 32'h0);
    checkOutput("rst_ack2", 32'(bus_if.cout_ack_o), 32'h0);
    checkOutput("rst_tready2", 32'(bus_if.s_dout_tready), 32'h0);
    model_reset();
    @(posedge sysclk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst                  = 1'b1;
    sync                 = 1'b0;
    cout_train           = 1'b0;
    dout_train           = 1'b0;
    bus_if.cout_word_i   = 32'h12345678;
    bus_if.cout_valid_i  = 1'b1;
    bus_if.s_dout_tdata  = 8'hAA;
    bus_if.s_dout_tvalid = 1'b1;
    bus_if.s_dout_tlast  = 1'b0;
    model_reset();
    @(posedge sysclk);
    #1;
    do_reset();
    applyStimulus(2500);
    do_reset();
    applyStimulus(2500);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
